// File: rtl/stage_pkg.sv
// ============================================================================
// Module   : stage_pkg
// Brief    : Shared stage encodings and role constants for stage controllers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package stage_pkg;

  localparam int c_state_w = 3;

  typedef enum logic [c_state_w-1:0] {
    ST_MENU  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_GAME  = 3'd2,
    ST_OVER  = 3'd3,
    ST_PAUSE = 3'd4
  } stage_e;

  localparam logic c_role_master = 1'b0;
  localparam logic c_role_slave  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/click_edge.sv
// ============================================================================
// Module   : click_edge
// Brief    : Rising-edge detector, one pulse per press of a level input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module click_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_pulse
);

  logic r_level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level_q <= 1'b0;
    end else begin
      r_level_q <= i_level;
    end
  end

  assign o_pulse = i_level & ~r_level_q;

endmodule

`default_nettype wire

// File: rtl/stage_ctrl_mp.sv
// ============================================================================
// Module   : stage_ctrl_mp
// Brief    : Multi-peer menu/sync/game/over stage controller with link mask,
//            start-ack synchronisation and winner resolution.
//            Optional pause stage enabled by defining STAGE_PAUSE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage_ctrl_mp
  import stage_pkg::*;
#(
  parameter int NUM_PEERS    = 1,
  parameter int SYNC_TIMEOUT = 1000000,
  parameter int TMR_W        = 20
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mouse_left,
  input  logic                 on_start_btn,
  input  logic                 on_connect_btn,
  input  logic                 on_return_btn,
  input  logic                 on_pause_btn,
  input  logic                 game_finish,
  input  logic [NUM_PEERS-1:0] rx_connect,
  input  logic [NUM_PEERS-1:0] rx_start,
  input  logic [NUM_PEERS-1:0] rx_finish,
  output logic                 tx_connect,
  output logic                 tx_start,
  output logic                 tx_finish,
  output logic                 game_init,
  output logic                 role,
  output logic [NUM_PEERS-1:0] link_mask,
  output logic                 sync_timeout,
  output logic                 local_won,
  output logic [2:0]           state
);

  stage_e               r_state, w_state_nxt;
  logic                 r_tx_connect, w_tx_connect_nxt;
  logic                 r_tx_start, w_tx_start_nxt;
  logic                 r_tx_finish, w_tx_finish_nxt;
  logic                 r_role, w_role_nxt;
  logic [NUM_PEERS-1:0] r_link_mask, w_link_mask_nxt;
  logic                 r_sync_timeout, w_sync_timeout_nxt;
  logic                 r_local_won, w_local_won_nxt;
  logic [TMR_W-1:0]     r_timer, w_timer_nxt;
  logic                 w_click;
  logic                 w_remote_fin;

  click_edge u_click_edge (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_level (mouse_left),
    .o_pulse (w_click)
  );

  assign w_remote_fin = |(rx_finish & r_link_mask);

`ifndef STAGE_PAUSE_EN
  logic w_unused_pause;
  assign w_unused_pause = on_pause_btn;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_MENU;
      r_tx_connect   <= 1'b0;
      r_tx_start     <= 1'b0;
      r_tx_finish    <= 1'b0;
      r_role         <= c_role_master;
      r_link_mask    <= '0;
      r_sync_timeout <= 1'b0;
      r_local_won    <= 1'b0;
      r_timer        <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_tx_connect   <= w_tx_connect_nxt;
      r_tx_start     <= w_tx_start_nxt;
      r_tx_finish    <= w_tx_finish_nxt;
      r_role         <= w_role_nxt;
      r_link_mask    <= w_link_mask_nxt;
      r_sync_timeout <= w_sync_timeout_nxt;
      r_local_won    <= w_local_won_nxt;
      r_timer        <= w_timer_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_tx_connect_nxt   = r_tx_connect;
    w_tx_start_nxt     = r_tx_start;
    w_tx_finish_nxt    = r_tx_finish;
    w_role_nxt         = r_role;
    w_link_mask_nxt    = r_link_mask;
    w_sync_timeout_nxt = r_sync_timeout;
    w_local_won_nxt    = r_local_won;
    w_timer_nxt        = r_timer;
    case (r_state)
      ST_MENU: begin
        w_link_mask_nxt = rx_connect & {NUM_PEERS{r_tx_connect}};
        if (w_click && on_connect_btn) begin
          w_tx_connect_nxt = 1'b1;
          w_role_nxt       = (|rx_connect) ? c_role_slave : c_role_master;
        end
        // Role as registered decides who may launch SYNC this cycle.
        if (r_role == c_role_master) begin
          if (w_click && on_start_btn) begin
            w_state_nxt        = ST_SYNC;
            w_tx_start_nxt     = 1'b1;
            w_tx_connect_nxt   = 1'b0;
            w_timer_nxt        = '0;
            w_sync_timeout_nxt = 1'b0;
          end
        end else if (|(rx_start & r_link_mask)) begin
          w_state_nxt      = ST_SYNC;
          w_tx_start_nxt   = 1'b1;
          w_tx_connect_nxt = 1'b0;
        end
      end
      ST_SYNC: begin
        if (r_role == c_role_slave) begin
          w_state_nxt = ST_GAME;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
          if ((rx_start & r_link_mask) == r_link_mask) begin
            w_state_nxt = ST_GAME;
          end else if (r_timer == TMR_W'(SYNC_TIMEOUT - 1)) begin
            // Drop peers that never acknowledged.
            w_state_nxt        = ST_GAME;
            w_link_mask_nxt    = r_link_mask & rx_start;
            w_sync_timeout_nxt = 1'b1;
          end
        end
      end
      ST_GAME: begin
        if (game_finish) begin
          w_state_nxt     = ST_OVER;
          w_tx_start_nxt  = 1'b0;
          w_tx_finish_nxt = 1'b1;
          w_local_won_nxt = 1'b1;
        end else if (w_remote_fin) begin
          w_state_nxt     = ST_OVER;
          w_tx_start_nxt  = 1'b0;
          w_local_won_nxt = 1'b0;
        end
`ifdef STAGE_PAUSE_EN
        else if (w_click && on_pause_btn) begin
          w_state_nxt = ST_PAUSE;
        end
`endif
      end
`ifdef STAGE_PAUSE_EN
      ST_PAUSE: begin
        if (w_remote_fin) begin
          w_state_nxt     = ST_OVER;
          w_tx_start_nxt  = 1'b0;
          w_local_won_nxt = 1'b0;
        end else if (w_click && on_pause_btn) begin
          w_state_nxt = ST_GAME;
        end
      end
`endif
      ST_OVER: begin
        if (w_click && on_return_btn) begin
          w_state_nxt     = ST_MENU;
          w_tx_finish_nxt = 1'b0;
          w_link_mask_nxt = '0;
          w_local_won_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt      = ST_MENU;
        w_tx_connect_nxt = 1'b0;
        w_tx_start_nxt   = 1'b0;
        w_tx_finish_nxt  = 1'b0;
        w_link_mask_nxt  = '0;
        w_local_won_nxt  = 1'b0;
      end
    endcase
  end

`ifdef STAGE_PAUSE_EN
  assign game_init = ~((r_state == ST_GAME) || (r_state == ST_PAUSE));
`else
  assign game_init = ~(r_state == ST_GAME);
`endif

  assign tx_connect   = r_tx_connect;
  assign tx_start     = r_tx_start;
  assign tx_finish    = r_tx_finish;
  assign role         = r_role;
  assign link_mask    = r_link_mask;
  assign sync_timeout = r_sync_timeout;
  assign local_won    = r_local_won;
  assign state        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_stage_ctrl_mp.sv
// ============================================================================
// Module   : tb_stage_ctrl_mp
// Brief    : Directed vector bench for stage_ctrl_mp (2 peers, short timeout).
//            Pause checks follow STAGE_PAUSE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stage_ctrl_mp;

  localparam int NUM_PEERS    = 2;
  localparam int SYNC_TIMEOUT = 16;
  localparam int TMR_W        = 5;

  // Button field: {mouse_left, start, connect, return, pause, game_finish}
  localparam logic [5:0] ML = 6'b100000;
  localparam logic [5:0] SB = 6'b010000;
  localparam logic [5:0] CB = 6'b001000;
  localparam logic [5:0] RB = 6'b000100;
  localparam logic [5:0] PB = 6'b000010;
  localparam logic [5:0] GF = 6'b000001;

  logic       clk;
  logic       reset_n;
  logic       mouse_left, on_start_btn, on_connect_btn, on_return_btn, on_pause_btn;
  logic       game_finish;
  logic [1:0] rx_connect, rx_start, rx_finish;
  logic       tx_connect, tx_start, tx_finish, game_init, role;
  logic [1:0] link_mask;
  logic       sync_timeout, local_won;
  logic [2:0] state;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string      name;
    logic [5:0] btn;
    logic [1:0] rxc;
    logic [1:0] rxs;
    logic [1:0] rxf;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];

  stage_ctrl_mp #(
    .NUM_PEERS    (NUM_PEERS),
    .SYNC_TIMEOUT (SYNC_TIMEOUT),
    .TMR_W        (TMR_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .mouse_left     (mouse_left),
    .on_start_btn   (on_start_btn),
    .on_connect_btn (on_connect_btn),
    .on_return_btn  (on_return_btn),
    .on_pause_btn   (on_pause_btn),
    .game_finish    (game_finish),
    .rx_connect     (rx_connect),
    .rx_start       (rx_start),
    .rx_finish      (rx_finish),
    .tx_connect     (tx_connect),
    .tx_start       (tx_start),
    .tx_finish      (tx_finish),
    .game_init      (game_init),
    .role           (role),
    .link_mask      (link_mask),
    .sync_timeout   (sync_timeout),
    .local_won      (local_won),
    .state          (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output word: {state, txc, txs, txf, game_init, role, mask, sto, won}
  function automatic logic [11:0] pk(input logic [2:0] st, input logic txc, input logic txs,
                                     input logic txf, input logic gi, input logic rl,
                                     input logic [1:0] msk, input logic sto, input logic won);
    return {st, txc, txs, txf, gi, rl, msk, sto, won};
  endfunction

  task automatic add(input string nm, input logic [5:0] b, input logic [1:0] c,
                     input logic [1:0] s, input logic [1:0] f, input logic [11:0] e);
    vec_t v;
    v.name = nm; v.btn = b; v.rxc = c; v.rxs = s; v.rxf = f; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [11:0] e);
    logic [11:0] act;
    act = {state, tx_connect, tx_start, tx_finish, game_init, role, link_mask,
           sync_timeout, local_won};
    n_vec++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (st,txc,txs,txf,gi,role,mask,sto,won)",
               nm, act, e);
    end
  endtask

  task automatic drive(input logic [5:0] b, input logic [1:0] c, input logic [1:0] s,
                       input logic [1:0] f);
    {mouse_left, on_start_btn, on_connect_btn, on_return_btn, on_pause_btn, game_finish} = b;
    rx_connect = c;
    rx_start   = s;
    rx_finish  = f;
  endtask

  task automatic step(input string nm, input logic [5:0] b, input logic [1:0] c,
                      input logic [1:0] s, input logic [1:0] f, input logic [11:0] e);
    drive(b, c, s, f);
    @(posedge clk);
    #1;
    check(nm, e);
  endtask

  initial begin
    // Master: connect, mask build, start, wait for ack, tied finish, return.
    add("idle",         6'd0,         2'b00, 2'b00, 2'b00, pk(0,0,0,0,1,0,2'b00,0,0));
    add("conn_click",   ML|CB,        2'b00, 2'b00, 2'b00, pk(0,1,0,0,1,0,2'b00,0,0));
    add("mask_01",      6'd0,         2'b01, 2'b00, 2'b00, pk(0,1,0,0,1,0,2'b01,0,0));
    add("start_click",  ML|SB,        2'b01, 2'b00, 2'b00, pk(1,0,1,0,1,0,2'b01,0,0));
    for (int i = 0; i < 5; i++)
      add("sync_wait",  6'd0,         2'b01, 2'b00, 2'b00, pk(1,0,1,0,1,0,2'b01,0,0));
    add("sync_ack",     6'd0,         2'b01, 2'b01, 2'b00, pk(2,0,1,0,0,0,2'b01,0,0));
    add("game_run",     6'd0,         2'b01, 2'b01, 2'b00, pk(2,0,1,0,0,0,2'b01,0,0));
    add("finish_tie",   GF,           2'b00, 2'b00, 2'b01, pk(3,0,0,1,1,0,2'b01,0,1));
    add("over_bad_btn", ML|SB|CB|GF,  2'b00, 2'b00, 2'b01, pk(3,0,0,1,1,0,2'b01,0,1));
    add("over_release", 6'd0,         2'b00, 2'b00, 2'b00, pk(3,0,0,1,1,0,2'b01,0,1));
    add("return_click", ML|RB,        2'b00, 2'b00, 2'b00, pk(0,0,0,0,1,0,2'b00,0,0));
    add("menu_release", 6'd0,         2'b00, 2'b00, 2'b00, pk(0,0,0,0,1,0,2'b00,0,0));
    add("conn_click2",  ML|CB,        2'b00, 2'b00, 2'b00, pk(0,1,0,0,1,0,2'b00,0,0));
    add("mask_11",      6'd0,         2'b11, 2'b00, 2'b00, pk(0,1,0,0,1,0,2'b11,0,0));
    add("start_click2", ML|SB,        2'b11, 2'b00, 2'b00, pk(1,0,1,0,1,0,2'b11,0,0));

    reset_n = 1'b0;
    drive(6'd0, 2'b00, 2'b00, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", pk(0,0,0,0,1,0,2'b00,0,0));
    reset_n = 1'b1;

    foreach (vecs[i]) step(vecs[i].name, vecs[i].btn, vecs[i].rxc, vecs[i].rxs,
                           vecs[i].rxf, vecs[i].exp);

    // Timeout: only peer 1 acks; 16 SYNC cycles in total, peer 0 dropped.
    for (int i = 0; i < SYNC_TIMEOUT - 1; i++)
      step("timeout_wait", 6'd0, 2'b11, 2'b10, 2'b00, pk(1,0,1,0,1,0,2'b11,0,0));
    step("timeout_exit",    6'd0, 2'b11, 2'b10, 2'b00, pk(2,0,1,0,0,0,2'b10,1,0));
    step("ignore_unmasked", 6'd0, 2'b00, 2'b00, 2'b01, pk(2,0,1,0,0,0,2'b10,1,0));

`ifdef STAGE_PAUSE_EN
    step("pause_enter",   ML|PB, 2'b00, 2'b00, 2'b00, pk(4,0,1,0,0,0,2'b10,1,0));
    step("pause_hold",    6'd0,  2'b00, 2'b00, 2'b00, pk(4,0,1,0,0,0,2'b10,1,0));
    step("pause_leave",   ML|PB, 2'b00, 2'b00, 2'b00, pk(2,0,1,0,0,0,2'b10,1,0));
`else
    step("pause_ignored", ML|PB, 2'b00, 2'b00, 2'b00, pk(2,0,1,0,0,0,2'b10,1,0));
    step("pause_hold",    6'd0,  2'b00, 2'b00, 2'b00, pk(2,0,1,0,0,0,2'b10,1,0));
    step("pause_ignored2",ML|PB, 2'b00, 2'b00, 2'b00, pk(2,0,1,0,0,0,2'b10,1,0));
`endif
    step("game_release",  6'd0,  2'b00, 2'b00, 2'b00, pk(2,0,1,0,0,0,2'b10,1,0));
    step("remote_finish", 6'd0,  2'b00, 2'b00, 2'b10, pk(3,0,0,0,1,0,2'b10,1,0));
    step("return_keep",   ML|RB, 2'b00, 2'b00, 2'b00, pk(0,0,0,0,1,0,2'b00,1,0));
    step("menu_idle",     6'd0,  2'b00, 2'b00, 2'b00, pk(0,0,0,0,1,0,2'b00,1,0));

    // Slave: connect while peer 0 requests, ack on its start, one-cycle SYNC.
    step("slave_conn",    ML|CB, 2'b01, 2'b00, 2'b00, pk(0,1,0,0,1,1,2'b00,1,0));
    step("slave_mask",    6'd0,  2'b01, 2'b00, 2'b00, pk(0,1,0,0,1,1,2'b01,1,0));
    step("slave_sync",    6'd0,  2'b01, 2'b01, 2'b00, pk(1,0,1,0,1,1,2'b01,1,0));
    step("slave_game",    6'd0,  2'b01, 2'b00, 2'b00, pk(2,0,1,0,0,1,2'b01,1,0));
    step("slave_unmask",  6'd0,  2'b00, 2'b00, 2'b10, pk(2,0,1,0,0,1,2'b01,1,0));
    step("slave_lose",    6'd0,  2'b00, 2'b00, 2'b01, pk(3,0,0,0,1,1,2'b01,1,0));
    step("slave_return",  ML|RB, 2'b00, 2'b00, 2'b00, pk(0,0,0,0,1,1,2'b00,1,0));
    step("slave_idle",    6'd0,  2'b00, 2'b00, 2'b00, pk(0,0,0,0,1,1,2'b00,1,0));

    // Master again, then reset asserted in the middle of SYNC.
    step("reconn_master", ML|CB, 2'b00, 2'b00, 2'b00, pk(0,1,0,0,1,0,2'b00,1,0));
    step("remask_01",     6'd0,  2'b01, 2'b00, 2'b00, pk(0,1,0,0,1,0,2'b01,1,0));
    step("restart",       ML|SB, 2'b01, 2'b00, 2'b00, pk(1,0,1,0,1,0,2'b01,0,0));
    step("resync_wait",   6'd0,  2'b01, 2'b00, 2'b00, pk(1,0,1,0,1,0,2'b01,0,0));
    reset_n = 1'b0;
    #2;
    check("async_reset", pk(0,0,0,0,1,0,2'b00,0,0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step("post_reset",    6'd0,  2'b01, 2'b00, 2'b00, pk(0,0,0,0,1,0,2'b00,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
